// File: rtl/uart_pkg.sv
// Shared definitions for the UART FIFO bridge.
//   UART_DATA_W  : byte width carried through both FIFOs and the core interface
//   tx_state_t   : TX launcher state encoding with TX_IDLE / TX_WAIT_BUSY / TX_WAIT_DONE
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t TX_IDLE      = 2'd0;
  localparam tx_state_t TX_WAIT_BUSY = 2'd1;
  localparam tx_state_t TX_WAIT_DONE = 2'd2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk, rstn     : clock, asynchronous active-low reset (empties FIFO, pointers to 0)
//   push, wdata   : write request and data; dropped when full unless a pop happens in the same cycle
//   pop           : read request; ignored when empty
//   rdata         : current head entry (valid while !empty)
//   full, empty   : status
//   count         : occupancy, 0..2**DEPTH_LOG2
module uart_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Byte buffering between the CPU register interface and the uart core.
// Ports:
//   clk, rstn                 : clock shared with the core, asynchronous active-low reset
//   tx_wr, tx_wdata           : push a byte into the TX FIFO
//   tx_full, tx_count         : TX FIFO status
//   rx_rd                     : pop the RX FIFO head
//   rx_rdata, rx_empty,
//   rx_count                  : RX FIFO head (fall-through) and status
//   clr_status                : clear the sticky error flags
//   tx_overrun, rx_overflow,
//   rx_frame_err              : sticky error flags
//   uart_transmit, uart_tx_byte : launch handshake to the core transmitter
//   uart_is_tx                : core transmitter busy
//   uart_received, uart_rx_byte,
//   uart_recv_error           : core receiver outputs, held until acknowledged
//   uart_recv_ack             : one-cycle acknowledge to the core receiver
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   tx_wr,
  input  logic [UART_DATA_W-1:0] tx_wdata,
  output logic                   tx_full,
  output logic [DEPTH_LOG2:0]    tx_count,
  input  logic                   rx_rd,
  output logic [UART_DATA_W-1:0] rx_rdata,
  output logic                   rx_empty,
  output logic [DEPTH_LOG2:0]    rx_count,
  input  logic                   clr_status,
  output logic                   tx_overrun,
  output logic                   rx_overflow,
  output logic                   rx_frame_err,
  output logic                   uart_transmit,
  output logic [UART_DATA_W-1:0] uart_tx_byte,
  input  logic                   uart_is_tx,
  input  logic                   uart_received,
  input  logic [UART_DATA_W-1:0] uart_rx_byte,
  input  logic                   uart_recv_error,
  output logic                   uart_recv_ack
);

  // ---------------------------------------------------------------------------
  // TX FIFO and launcher
  // ---------------------------------------------------------------------------
  logic                   tx_empty, tx_push, tx_pop, launch;
  logic [UART_DATA_W-1:0] tx_head;
  tx_state_t              tx_state_q, tx_state_d;
  logic                   transmit_q;
  logic [UART_DATA_W-1:0] tx_byte_q;

  // A write into a full TX FIFO is always dropped, even if the launcher pops that cycle.
  assign tx_push = tx_wr & ~tx_full;

  uart_sync_fifo #(
    .WIDTH      (UART_DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    launch     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !uart_is_tx) begin
          launch     = 1'b1;
          tx_state_d = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: if (uart_is_tx)  tx_state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!uart_is_tx) tx_state_d = TX_IDLE;
      default:      tx_state_d = TX_IDLE;
    endcase
  end

  assign tx_pop = launch;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      transmit_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      transmit_q <= launch;
      if (launch) begin
        tx_byte_q <= tx_head;
      end
    end
  end

  assign uart_transmit = transmit_q;
  assign uart_tx_byte  = tx_byte_q;

  // ---------------------------------------------------------------------------
  // RX capture and acknowledge
  // ---------------------------------------------------------------------------
  logic rx_full, rx_take, err_take, ack_q;
  logic overflow_set, frame_set, overrun_set;
  logic overrun_q, overflow_q, frame_q;

  // While ack is high the core still shows the old byte; it drops received at the end of
  // the ack cycle, so ack_q masks a second capture of the same byte.
  assign rx_take  = uart_received & ~ack_q;
  assign err_take = uart_recv_error & ~ack_q;

  uart_sync_fifo #(
    .WIDTH      (UART_DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_take),
    .wdata (uart_rx_byte),
    .pop   (rx_rd),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Full implies non-empty, so a simultaneous rx_rd always frees a slot.
  assign overflow_set = rx_take & rx_full & ~rx_rd;
  assign frame_set    = err_take;
  assign overrun_set  = tx_wr & tx_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q      <= 1'b0;
      overrun_q  <= 1'b0;
      overflow_q <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      ack_q      <= rx_take | err_take;
      // Set beats clear when both happen in one cycle.
      overrun_q  <= overrun_set  | (overrun_q  & ~clr_status);
      overflow_q <= overflow_set | (overflow_q & ~clr_status);
      frame_q    <= frame_set    | (frame_q    & ~clr_status);
    end
  end

  assign uart_recv_ack = ack_q;
  assign tx_overrun    = overrun_q;
  assign rx_overflow   = overflow_q;
  assign rx_frame_err  = frame_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge with a simple uart core model.
module tb_uart_fifo_bridge;

  localparam int unsigned DL    = 4;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tx_wr;
  logic [7:0] tx_wdata;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       rx_rd;
  logic [7:0] rx_rdata;
  logic       rx_empty;
  logic [4:0] rx_count;
  logic       clr_status;
  logic       tx_overrun, rx_overflow, rx_frame_err;
  logic       uart_transmit;
  logic [7:0] uart_tx_byte;
  logic       uart_is_tx;
  logic       uart_received;
  logic [7:0] uart_rx_byte;
  logic       uart_recv_error;
  logic       uart_recv_ack;

  uart_fifo_bridge #(.DEPTH_LOG2(DL)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .tx_wr           (tx_wr),
    .tx_wdata        (tx_wdata),
    .tx_full         (tx_full),
    .tx_count        (tx_count),
    .rx_rd           (rx_rd),
    .rx_rdata        (rx_rdata),
    .rx_empty        (rx_empty),
    .rx_count        (rx_count),
    .clr_status      (clr_status),
    .tx_overrun      (tx_overrun),
    .rx_overflow     (rx_overflow),
    .rx_frame_err    (rx_frame_err),
    .uart_transmit   (uart_transmit),
    .uart_tx_byte    (uart_tx_byte),
    .uart_is_tx      (uart_is_tx),
    .uart_received   (uart_received),
    .uart_rx_byte    (uart_rx_byte),
    .uart_recv_error (uart_recv_error),
    .uart_recv_ack   (uart_recv_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Core model: busy for busy_len cycles after each transmit pulse, or forced busy.
  bit         hold_busy = 1'b1;
  int         busy_len  = 40;
  int         busy_cnt  = 0;
  int         double_pulse = 0;
  bit         prev_tx   = 1'b0;
  logic [7:0] tx_seen[$];

  // Reference RX contents (order of bytes accepted by the bridge).
  logic [7:0] rx_model[$];

  initial begin
    uart_is_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (uart_transmit) begin
        tx_seen.push_back(uart_tx_byte);
        if (prev_tx) double_pulse++;
      end
      prev_tx = uart_transmit;
      if (hold_busy) uart_is_tx = 1'b1;
      else if (busy_cnt > 0) begin
        busy_cnt--;
        uart_is_tx = (busy_cnt != 0);
      end else if (uart_transmit) begin
        busy_cnt   = busy_len;
        uart_is_tx = 1'b1;
      end else uart_is_tx = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_tx(input logic [7:0] b);
    tx_wr = 1'b1; tx_wdata = b;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic pop_rx();
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  // Present a byte/error like the core does: held until ack is seen, dropped after the ack cycle.
  task automatic rx_send(input logic [7:0] b, input bit rcv, input bit err, input bit rd,
                         input bit clr, output int acks);
    uart_received = rcv; uart_recv_error = err; uart_rx_byte = b;
    rx_rd = rd; clr_status = clr;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_rd = 1'b0; clr_status = 1'b0;
      if (uart_recv_ack) begin
        acks++;
        break;
      end
    end
    uart_received = 1'b0; uart_recv_error = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (uart_recv_ack) acks++;
    end
  endtask

  task automatic fill_rx(input int n);
    int acks;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      rx_send(b, 1'b1, 1'b0, 1'b0, 1'b0, acks);
      rx_model.push_back(b);
      total++;
      if (acks != 1) begin
        bad++; $display("FAIL fill_ack[%0d]: got %0d want 1", i, acks);
      end
    end
  endtask

  task automatic drain_rx_check(input string tag);
    logic [7:0] exp;
    while (rx_model.size() > 0) begin
      exp = rx_model.pop_front();
      total++;
      if (rx_rdata !== exp) begin
        bad++; $display("FAIL %s_data: got %02h want %02h", tag, rx_rdata, exp);
      end
      pop_rx();
    end
    total++;
    if (rx_empty !== 1'b1 || rx_count !== 5'd0) begin
      bad++; $display("FAIL %s_empty: got empty=%b count=%0d want 1/0", tag, rx_empty, rx_count);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; tx_wr = 0; tx_wdata = 0; rx_rd = 0; clr_status = 0;
    uart_received = 0; uart_rx_byte = 0; uart_recv_error = 0; hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (tx_full !== 1'b0 || tx_count !== 5'd0) begin
      bad++; $display("FAIL reset_tx: got full=%b count=%0d want 0/0", tx_full, tx_count);
    end
    total++;
    if (rx_empty !== 1'b1 || rx_count !== 5'd0 || rx_rdata !== 8'h00) begin
      bad++; $display("FAIL reset_rx: got empty=%b count=%0d rdata=%02h want 1/0/00",
                      rx_empty, rx_count, rx_rdata);
    end
    total++;
    if ({tx_overrun, rx_overflow, rx_frame_err, uart_transmit, uart_recv_ack} !== 5'b0 ||
        uart_tx_byte !== 8'h00) begin
      bad++; $display("FAIL reset_outs: got flags=%b%b%b tx=%b ack=%b byte=%02h want all 0",
                      tx_overrun, rx_overflow, rx_frame_err, uart_transmit, uart_recv_ack,
                      uart_tx_byte);
    end
    rstn = 1'b1;
    tx_seen.delete();
    repeat (20) @(negedge clk);
    total++;
    if (tx_seen.size() != 0) begin
      bad++; $display("FAIL reset_busy_launch: got %0d pulses want 0", tx_seen.size());
    end
    hold_busy = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (tx_seen.size() != 0) begin
      bad++; $display("FAIL reset_idle_launch: got %0d pulses want 0", tx_seen.size());
    end
  endtask

  task automatic test_tx_drain();
    logic [7:0] exp[3];
    int i;
    exp[0] = 8'h55; exp[1] = 8'hA3; exp[2] = 8'h0F;
    hold_busy = 1'b1; busy_len = 40;
    repeat (2) @(negedge clk);
    tx_seen.delete(); double_pulse = 0;
    for (int k = 0; k < 3; k++) push_tx(exp[k]);
    total++;
    if (tx_count !== 5'd3) begin
      bad++; $display("FAIL drain_count3: got %0d want 3", tx_count);
    end
    hold_busy = 1'b0;
    i = 0;
    while (i < 400 && !(tx_seen.size() == 3 && tx_count == 0 && !uart_is_tx)) begin
      @(negedge clk); i++;
    end
    total++;
    if (tx_seen.size() != 3) begin
      bad++; $display("FAIL drain_pulses: got %0d want 3", tx_seen.size());
    end
    for (int k = 0; k < 3 && k < tx_seen.size(); k++) begin
      total++;
      if (tx_seen[k] !== exp[k]) begin
        bad++; $display("FAIL drain_byte[%0d]: got %02h want %02h", k, tx_seen[k], exp[k]);
      end
    end
    total++;
    if (tx_count !== 5'd0 || double_pulse != 0) begin
      bad++; $display("FAIL drain_end: got count=%0d wide=%0d want 0/0", tx_count, double_pulse);
    end
    total++;
    if (uart_tx_byte !== 8'h0F) begin
      bad++; $display("FAIL drain_hold: got %02h want 0f", uart_tx_byte);
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] exp[$];
    logic [7:0] b;
    int i;
    hold_busy = 1'b1; busy_len = 4;
    repeat (2) @(negedge clk);
    tx_seen.delete(); double_pulse = 0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      b = 8'($urandom);
      push_tx(b);
      if (exp.size() < DEPTH) exp.push_back(b);
    end
    total++;
    if (tx_full !== 1'b1 || tx_count !== 5'd16 || tx_overrun !== 1'b1) begin
      bad++; $display("FAIL full_state: got full=%b count=%0d ovr=%b want 1/16/1",
                      tx_full, tx_count, tx_overrun);
    end
    hold_busy = 1'b0;
    i = 0;
    while (i < 1500 && !(tx_seen.size() >= DEPTH && tx_count == 0 && !uart_is_tx)) begin
      @(negedge clk); i++;
    end
    repeat (10) @(negedge clk);
    total++;
    if (tx_seen.size() != DEPTH) begin
      bad++; $display("FAIL full_sent: got %0d want %0d", tx_seen.size(), DEPTH);
    end
    for (int k = 0; k < DEPTH && k < tx_seen.size(); k++) begin
      total++;
      if (tx_seen[k] !== exp[k]) begin
        bad++; $display("FAIL full_byte[%0d]: got %02h want %02h", k, tx_seen[k], exp[k]);
      end
    end
    total++;
    if (tx_full !== 1'b0 || double_pulse != 0) begin
      bad++; $display("FAIL full_after: got full=%b wide=%0d want 0/0", tx_full, double_pulse);
    end
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    total++;
    if (tx_overrun !== 1'b0) begin
      bad++; $display("FAIL full_clr: got %b want 0", tx_overrun);
    end
  endtask

  task automatic test_rx_path();
    int acks;
    rx_model.delete();
    rx_send(8'hC8, 1'b1, 1'b0, 1'b0, 1'b0, acks);
    total++;
    if (acks != 1) begin
      bad++; $display("FAIL rx_ack: got %0d want 1", acks);
    end
    total++;
    if (rx_count !== 5'd1 || rx_rdata !== 8'hC8 || rx_empty !== 1'b0) begin
      bad++; $display("FAIL rx_first: got count=%0d data=%02h empty=%b want 1/c8/0",
                      rx_count, rx_rdata, rx_empty);
    end
    pop_rx();
    total++;
    if (rx_empty !== 1'b1 || rx_count !== 5'd0) begin
      bad++; $display("FAIL rx_pop: got empty=%b count=%0d want 1/0", rx_empty, rx_count);
    end
    pop_rx();
    total++;
    if (rx_count !== 5'd0 || rx_overflow !== 1'b0 || rx_frame_err !== 1'b0) begin
      bad++; $display("FAIL rx_pop_empty: got count=%0d ovf=%b fe=%b want 0/0/0",
                      rx_count, rx_overflow, rx_frame_err);
    end
    fill_rx(5);
    total++;
    if (rx_count !== 5'd5) begin
      bad++; $display("FAIL rx_count5: got %0d want 5", rx_count);
    end
    drain_rx_check("rx_rand");
  endtask

  task automatic test_rx_overflow();
    int acks;
    rx_model.delete();
    fill_rx(DEPTH);
    total++;
    if (rx_count !== 5'd16 || rx_overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_fill: got count=%0d ovf=%b want 16/0", rx_count, rx_overflow);
    end
    rx_send(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, acks);
    total++;
    if (acks != 1 || rx_overflow !== 1'b1 || rx_count !== 5'd16) begin
      bad++; $display("FAIL ovf_17th: got ack=%0d ovf=%b count=%0d want 1/1/16",
                      acks, rx_overflow, rx_count);
    end
    rx_send(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, acks);
    total++;
    if (acks != 1 || rx_frame_err !== 1'b1 || rx_count !== 5'd16) begin
      bad++; $display("FAIL ovf_err: got ack=%0d fe=%b count=%0d want 1/1/16",
                      acks, rx_frame_err, rx_count);
    end
    rx_send(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, acks);
    total++;
    if (acks != 1 || rx_frame_err !== 1'b1 || rx_overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_clr_race: got ack=%0d fe=%b ovf=%b want 1/1/0",
                      acks, rx_frame_err, rx_overflow);
    end
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    total++;
    if (rx_frame_err !== 1'b0) begin
      bad++; $display("FAIL ovf_clr: got fe=%b want 0", rx_frame_err);
    end
    drain_rx_check("ovf");
  endtask

  task automatic test_simultaneous();
    int acks;
    logic [7:0] last;
    rx_model.delete();
    fill_rx(DEPTH);
    void'(rx_model.pop_front());
    rx_model.push_back(8'h3C);
    rx_send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, acks);
    total++;
    if (acks != 1 || rx_count !== 5'd16 || rx_overflow !== 1'b0) begin
      bad++; $display("FAIL sim_state: got ack=%0d count=%0d ovf=%b want 1/16/0",
                      acks, rx_count, rx_overflow);
    end
    while (rx_model.size() > 1) begin
      total++;
      if (rx_rdata !== rx_model[0]) begin
        bad++; $display("FAIL sim_data: got %02h want %02h", rx_rdata, rx_model[0]);
      end
      void'(rx_model.pop_front());
      pop_rx();
    end
    last = rx_rdata;
    rx_model.delete();
    total++;
    if (last !== 8'h3C || rx_count !== 5'd1) begin
      bad++; $display("FAIL sim_last: got %02h count=%0d want 3c/1", last, rx_count);
    end
    pop_rx();
  endtask

  task automatic test_reset_mid();
    int acks;
    int i;
    int seen;
    hold_busy = 1'b1; busy_len = 30;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) push_tx(8'($urandom));
    rx_send(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, acks);
    rx_send(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, acks);
    hold_busy = 1'b0;
    seen = tx_seen.size();
    i = 0;
    while (i < 50 && tx_seen.size() == seen) begin
      @(negedge clk); i++;
    end
    rstn = 1'b0;
    @(negedge clk);
    total++;
    if (tx_count !== 5'd0 || rx_count !== 5'd0 || rx_empty !== 1'b1 || uart_transmit !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got txc=%0d rxc=%0d empty=%b tx=%b want 0/0/1/0",
                      tx_count, rx_count, rx_empty, uart_transmit);
    end
    rstn = 1'b1;
    seen = tx_seen.size();
    repeat (60) @(negedge clk);
    total++;
    if (tx_seen.size() != seen) begin
      bad++; $display("FAIL mid_no_launch: got %0d extra pulses want 0", tx_seen.size() - seen);
    end
  endtask

  initial begin
    test_reset();
    test_tx_drain();
    test_tx_full();
    test_rx_path();
    test_rx_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
